osc_freq_meter: RTL and testbench

- Measurement end of the OSC interface.
- Drives OSC's Start enable, receives its free-running Tout, and counts Tout rising edges over a fixed window of system clocks.
- Returns an edge count proportional to oscillator frequency, with a done pulse and an overflow flag.
- Sits between OSC and any host logic that requests and reads frequency measurements.

---
 rtl/osc_meter_pkg.sv | 18 +
 rtl/osc_sync_edge.sv | 27 ++
 rtl/osc_freq_meter.sv | 131 +++++++++++++
 tb/tb_osc_freq_meter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/osc_meter_pkg.sv
// Shared definitions for the OSC frequency meter: FSM encoding and counter sizing.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meter_state_t;

  // One timer serves both the settle delay and the measurement window.
  function automatic int win_cnt_w(input int window, input int settle);
    int m;
    m = (window > settle) ? window : settle;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/osc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous oscillator output plus a
// one-cycle rising-edge pulse taken from the last synchronizer stage.
module osc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts oscillator rising edges over a fixed window of clk cycles after a settle delay.
// Optional continuous mode (back-to-back windows while req_i stays high): OSC_METER_CONT_EN.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int WINDOW      = 50000,
  parameter int SETTLE      = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             tout_i,
  output logic             start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  localparam int TW = win_cnt_w(WINDOW, SETTLE);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WIN_LAST    = TW'(WINDOW - 1);

  meter_state_t     state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_int_q, ovf_int_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             tout_edge;
  logic [CNT_W-1:0] meas_cnt;
  logic             meas_ovf;

  osc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (tout_i),
    .edge_o  (tout_edge)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      ovf_int_q  <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_int_q  <= ovf_int_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Saturating increment; used both for the running count and the final latch.
  always_comb begin
    meas_cnt = edge_cnt_q;
    meas_ovf = ovf_int_q;
    if (tout_edge) begin
      if (&edge_cnt_q) meas_ovf = 1'b1;
      else             meas_cnt = edge_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    edge_cnt_d = edge_cnt_q;
    ovf_int_d  = ovf_int_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (req_i) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d    = ST_MEASURE;
          tmr_d      = '0;
          edge_cnt_d = '0;
          ovf_int_d  = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_MEASURE: begin
        edge_cnt_d = meas_cnt;
        ovf_int_d  = meas_ovf;
        if (tmr_q == WIN_LAST) begin
          state_d = ST_DONE;
          tmr_d   = '0;
          count_d = meas_cnt;
          ovf_d   = meas_ovf;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef OSC_METER_CONT_EN
        if (req_i) begin
          state_d    = ST_MEASURE;
          tmr_d      = '0;
          edge_cnt_d = '0;
          ovf_int_d  = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef OSC_METER_CONT_EN
  // Oscillator stays enabled through DONE so back-to-back windows never stop it.
  assign start_o = (state_q != ST_IDLE);
`else
  assign start_o = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
`endif
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: directed scenarios plus random oscillator periods,
// checked against a time-domain edge-counting model.
`timescale 1ns/1ps
module tb_osc_freq_meter;

  localparam int W  = 100;
  localparam int S  = 4;
  localparam int SY = 2;
`ifdef OSC_METER_CONT_EN
  localparam int B2B_GAP = W + 1;
  localparam int B2B_LOW = 0;
`else
  localparam int B2B_GAP = W + S + 2;
  localparam int B2B_LOW = 2;
`endif

  logic        clk, rst, req, tout;
  logic        start, busy, done, ovf;
  logic [15:0] count;
  logic        start_s, busy_s, done_s, ovf_s;
  logic [3:0]  count_s;

  int  checks = 0;
  int  errors = 0;
  int  tout_half = 50;
  time rises[$];

  osc_freq_meter #(.WINDOW(W), .SETTLE(S), .CNT_W(16), .SYNC_STAGES(SY)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .tout_i(tout),
    .start_o(start), .busy_o(busy), .done_o(done), .count_o(count), .ovf_o(ovf)
  );

  osc_freq_meter #(.WINDOW(W), .SETTLE(S), .CNT_W(4), .SYNC_STAGES(SY)) dut_sat (
    .clk_i(clk), .rst_i(rst), .req_i(req), .tout_i(tout),
    .start_o(start_s), .busy_o(busy_s), .done_o(done_s), .count_o(count_s), .ovf_o(ovf_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tout changes only on multiples of 10 ns, i.e. midway between clk rising edges.
  initial begin
    tout = 1'b0;
    forever begin
      if (tout_half == 0) begin
        tout = 1'b0;
        #10;
      end else begin
        #(tout_half);
        tout = ~tout;
        if (tout) rises.push_back($time);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // An edge is counted when its synchronized pulse occupies a MEASURE cycle; the
  // window ends at the clock edge that opens DONE, shifted back by the sync depth.
  function automatic int rises_before_done(input time td);
    time lo, hi;
    int  n;
    lo = td - (W + SY) * 10;
    hi = td - SY * 10;
    n  = 0;
    foreach (rises[i]) if (rises[i] > lo && rises[i] < hi) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag);
    int n;
    n = rises_before_done($time - 1);
    check({tag, "_count"}, 32'(count), 32'(n));
    check({tag, "_ovf"}, 32'(ovf), 32'(n > 65535));
    check({tag, "_count4"}, 32'(count_s), 32'((n > 15) ? 15 : n));
    check({tag, "_ovf4"}, 32'(ovf_s), 32'(n > 15));
    $display("measure %s: edges=%0d count=%0d ovf=%0d count4=%0d ovf4=%0d",
             tag, n, count, ovf, count_s, ovf_s);
  endtask

  task automatic measure(input string tag);
    int k;
    req = 1'b1;
    tick();
    req = 1'b0;
    check({tag, "_start"}, 32'(start), 32'd1);
    k = 1;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(S + W + 1));
    check_result(tag);
    tick();
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic back_to_back();
    int k, nd, last, low;
    req = 1'b1;
    k = 0; nd = 0; last = 0; low = 0;
    while (nd < 3 && k < 500) begin
      tick();
      k++;
      if (done) begin
        if (nd == 0) check("b2b_first_latency", 32'(k), 32'(S + W + 1));
        else begin
          check("b2b_gap", 32'(k - last), 32'(B2B_GAP));
          check("b2b_start_low", 32'(low), 32'(B2B_LOW));
        end
        check_result("b2b");
        last = k;
        nd++;
        low = start ? 0 : 1;
      end else if (!start) begin
        low++;
      end
    end
    check("b2b_done_count", 32'(nd), 32'd3);
    req = 1'b0;
    k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check("b2b_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int k, p;
    bit seen_start, seen_busy, seen_done;
    rst = 1'b1;
    req = 1'b0;
    repeat (3) tick();
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    seen_start = 0; seen_busy = 0; seen_done = 0;
    repeat (500) begin
      tick();
      seen_start |= start;
      seen_busy  |= busy;
      seen_done  |= done;
    end
    check("idle_start", 32'(seen_start), 32'd0);
    check("idle_busy", 32'(seen_busy), 32'd0);
    check("idle_done", 32'(seen_done), 32'd0);
    check("idle_count", 32'(count), 32'd0);

    measure("nominal");
    check("nominal_ten", 32'(count), 32'd10);

    tout_half = 0;
    repeat (40) tick();
    measure("dead");

    tout_half = 20;
    repeat (40) tick();
    measure("sat");
    check("sat_count4_abs", 32'(count_s), 32'd15);
    check("sat_ovf4_abs", 32'(ovf_s), 32'd1);

    tout_half = 50;
    repeat (40) tick();
    measure("pre_rst");
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (S + 49) tick();
    check("midrst_busy_before", 32'(busy), 32'd1);
    check("midrst_count_held", 32'(count), 32'd10);
    rst = 1'b1;
    #1;
    check("midrst_start", 32'(start), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    seen_done = 0;
    repeat (120) begin
      tick();
      seen_done |= done;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    measure("post_rst");

    back_to_back();

    for (int i = 0; i < 6; i++) begin
      p = $urandom_range(0, 15);
      tout_half = (p == 0) ? 0 : p * 10 + 10;
      k = 40 + $urandom_range(0, 20);
      repeat (k) tick();
      $display("random step %0d: tout_half=%0d ns", i, tout_half);
      measure("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
